svm_feature_sequencer: RTL and testbench

Parametrised successor to the SVM top-level feature loader. It accepts one sample's features over a valid/ready stream and buffers them. It then drives the SVM core with a lane-parallel chunk sequence for every support vector, with core-side backpressure, collects the core's result, and returns it over a valid/ready handshake. Unlike the previous run-once loader, it processes back-to-back samples indefinitely and supports a configurable lane count and feature count.

---
 rtl/svm_feature_sequencer.sv | 131 +++++++++++++
 tb/tb_svm_feature_sequencer.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/svm_feature_sequencer.sv
// Buffers one sample's features, then streams them to the SVM core as lane-parallel
// chunks for every support vector, and returns the core's result over a handshake.
module svm_feature_sequencer #(
  parameter int FUNCTION     = 0,
  parameter int CLASS_WIDE   = 2,
  parameter int SVM_NUM      = 1024,
  parameter int FEATURE_WIDE = 7,
  parameter int FEATURE_NUM  = 11,
  parameter int LANES        = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 feat_valid,
  output logic                                 feat_ready,
  input  logic [FEATURE_WIDE+5:0]              feat_data,
  output logic                                 out_valid,
  input  logic                                 core_ready,
  output logic [LANES*(FEATURE_WIDE+6)-1:0]    out_data,
  output logic [10:0]                          out_sv_addr,
  output logic [4:0]                           out_chunk,
  output logic                                 out_first,
  output logic                                 out_last,
  output logic [10:0]                          out_bias_addr,
  output logic                                 out_mode,
  input  logic                                 core_done,
  input  logic [CLASS_WIDE-1:0]                core_result,
  output logic                                 res_valid,
  input  logic                                 res_ready,
  output logic [CLASS_WIDE-1:0]                res_data,
  output logic                                 busy
);

  localparam int FW     = FEATURE_WIDE + 6;
  localparam int CHUNKS = (FEATURE_NUM + LANES - 1) / LANES;
  localparam int NSLOT  = CHUNKS * LANES;

  localparam logic [5:0]  LAST_FEAT  = 6'(FEATURE_NUM - 1);
  localparam logic [4:0]  LAST_CHUNK = 5'(CHUNKS - 1);
  localparam logic [10:0] LAST_SV    = 11'(SVM_NUM - 1);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, WAIT, RESULT} state_t;

  state_t              state;
  logic [5:0]          f_cnt;
  // Padded to whole chunks; slots past FEATURE_NUM are never written, so they read as 0.
  logic [NSLOT*FW-1:0] fbuf;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= LOAD;
      f_cnt         <= '0;
      fbuf          <= '0;
      out_sv_addr   <= '0;
      out_chunk     <= '0;
      out_bias_addr <= '0;
      res_data      <= '0;
      feat_ready    <= 1'b1;
      out_valid     <= 1'b0;
      res_valid     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          fbuf       <= '0;
          f_cnt      <= '0;
          feat_ready <= 1'b1;
          state      <= LOAD;
        end
        LOAD: begin
          if (feat_valid) begin
            for (int i = 0; i < FEATURE_NUM; i++)
              if (f_cnt == 6'(i)) fbuf[i*FW +: FW] <= feat_data;
            if (f_cnt == LAST_FEAT) begin
              f_cnt       <= '0;
              feat_ready  <= 1'b0;
              out_valid   <= 1'b1;
              out_sv_addr <= '0;
              out_chunk   <= '0;
              state       <= RUN;
            end else begin
              f_cnt <= f_cnt + 6'd1;
            end
          end
        end
        RUN: begin
          if (core_ready) begin
            if (out_chunk == LAST_CHUNK) begin
              out_chunk <= '0;
              if (out_sv_addr == LAST_SV) begin
                out_sv_addr <= '0;
                out_valid   <= 1'b0;
                state       <= WAIT;
              end else begin
                out_sv_addr <= out_sv_addr + 11'd1;
              end
            end else begin
              out_chunk <= out_chunk + 5'd1;
            end
          end
        end
        WAIT: begin
          if (core_done) begin
            res_data  <= core_result;
            res_valid <= 1'b1;
            state     <= RESULT;
          end
        end
        RESULT: begin
          if (res_ready) begin
            out_bias_addr <= out_bias_addr + 11'd1;
            res_valid     <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  always_comb begin
    out_data = '0;
    for (int c = 0; c < CHUNKS; c++)
      if (out_valid && out_chunk == 5'(c))
        out_data = fbuf[c*LANES*FW +: LANES*FW];
  end

  assign out_first = out_valid && (out_chunk == 5'd0);
  assign out_last  = out_valid && (out_chunk == LAST_CHUNK);
  assign out_mode  = 1'(FUNCTION);
  assign busy      = !((state == IDLE) || (state == LOAD && f_cnt == 6'd0));

endmodule

// File: tb/tb_svm_feature_sequencer.sv
// Randomised bench for svm_feature_sequencer: a sample-level model predicts every output
// each cycle, a few literal checks pin that model, and a second instance covers LANES=16.
module tb_svm_feature_sequencer;

  localparam int FUNCTION     = 0;
  localparam int CLASS_WIDE   = 2;
  localparam int SVM_NUM      = 4;
  localparam int FEATURE_WIDE = 7;
  localparam int FEATURE_NUM  = 11;
  localparam int LANES        = 8;
  localparam int FW           = FEATURE_WIDE + 6;
  localparam int CHUNKS       = (FEATURE_NUM + LANES - 1) / LANES;
  localparam int W_LANES      = 16;

  logic clk;
  logic rst_n, feat_valid, feat_ready, out_valid, core_ready, out_first, out_last;
  logic out_mode, core_done, res_valid, res_ready, busy;
  logic [FW-1:0]           feat_data;
  logic [LANES*FW-1:0]     out_data;
  logic [10:0]             out_sv_addr, out_bias_addr;
  logic [4:0]              out_chunk;
  logic [CLASS_WIDE-1:0]   core_result, res_data;

  logic w_rst_n, w_feat_valid, w_feat_ready, w_out_valid, w_core_ready, w_out_first, w_out_last;
  logic w_out_mode, w_core_done, w_res_valid, w_res_ready, w_busy;
  logic [FW-1:0]           w_feat_data;
  logic [W_LANES*FW-1:0]   w_out_data;
  logic [10:0]             w_out_sv_addr, w_out_bias_addr;
  logic [4:0]              w_out_chunk;
  logic [CLASS_WIDE-1:0]   w_core_result, w_res_data;

  svm_feature_sequencer #(
    .FUNCTION(FUNCTION), .CLASS_WIDE(CLASS_WIDE), .SVM_NUM(SVM_NUM),
    .FEATURE_WIDE(FEATURE_WIDE), .FEATURE_NUM(FEATURE_NUM), .LANES(LANES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .feat_valid(feat_valid), .feat_ready(feat_ready),
    .feat_data(feat_data), .out_valid(out_valid), .core_ready(core_ready),
    .out_data(out_data), .out_sv_addr(out_sv_addr), .out_chunk(out_chunk),
    .out_first(out_first), .out_last(out_last), .out_bias_addr(out_bias_addr),
    .out_mode(out_mode), .core_done(core_done), .core_result(core_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy)
  );

  svm_feature_sequencer #(
    .FUNCTION(1), .CLASS_WIDE(CLASS_WIDE), .SVM_NUM(1),
    .FEATURE_WIDE(FEATURE_WIDE), .FEATURE_NUM(FEATURE_NUM), .LANES(W_LANES)
  ) dut_wide (
    .clk(clk), .rst_n(w_rst_n), .feat_valid(w_feat_valid), .feat_ready(w_feat_ready),
    .feat_data(w_feat_data), .out_valid(w_out_valid), .core_ready(w_core_ready),
    .out_data(w_out_data), .out_sv_addr(w_out_sv_addr), .out_chunk(w_out_chunk),
    .out_first(w_out_first), .out_last(w_out_last), .out_bias_addr(w_out_bias_addr),
    .out_mode(w_out_mode), .core_done(w_core_done), .core_result(w_core_result),
    .res_valid(w_res_valid), .res_ready(w_res_ready), .res_data(w_res_data), .busy(w_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Sample-level reference model, evaluated on the falling edge.
  typedef enum int {M_IDLE, M_LOAD, M_RUN, M_WAIT, M_RESULT} m_phase_t;
  m_phase_t              m_phase = M_LOAD;
  bit                    armed = 1'b0;
  int                    m_beat = 0;
  int                    m_bias = 0;
  logic [CLASS_WIDE-1:0] m_res = '0;
  logic [FW-1:0]         mq[$];
  logic [FW-1:0]         m_feat [FEATURE_NUM];
  logic [255:0]          mon_exp;
  int                    mon_ch;

  always @(negedge clk) begin
    if (armed) begin
      checkOutput("feat_ready", feat_ready, m_phase == M_LOAD);
      checkOutput("out_valid", out_valid, m_phase == M_RUN);
      checkOutput("res_valid", res_valid, m_phase == M_RESULT);
      checkOutput("busy", busy, !(m_phase == M_IDLE || (m_phase == M_LOAD && mq.size() == 0)));
      checkOutput("bias_addr", out_bias_addr, m_bias);
      checkOutput("res_data", res_data, m_res);
      checkOutput("out_mode", out_mode, FUNCTION);
      if (m_phase == M_RUN) begin
        mon_ch  = m_beat % CHUNKS;
        mon_exp = '0;
        for (int k = 0; k < LANES; k++)
          if (mon_ch * LANES + k < FEATURE_NUM) mon_exp[k*FW +: FW] = m_feat[mon_ch * LANES + k];
        checkOutput("beat_data", out_data, mon_exp);
        checkOutput("beat_sv", out_sv_addr, m_beat / CHUNKS);
        checkOutput("beat_chunk", out_chunk, mon_ch);
        checkOutput("beat_first", out_first, mon_ch == 0);
        checkOutput("beat_last", out_last, mon_ch == CHUNKS - 1);
      end
    end
    if (!rst_n) begin
      armed   = 1'b1;
      m_phase = M_LOAD;
      mq.delete();
      m_beat  = 0;
      m_bias  = 0;
      m_res   = '0;
    end else if (armed) begin
      case (m_phase)
        M_IDLE: m_phase = M_LOAD;
        M_LOAD: if (feat_valid) begin
          mq.push_back(feat_data);
          if (mq.size() == FEATURE_NUM) begin
            for (int i = 0; i < FEATURE_NUM; i++) m_feat[i] = mq[i];
            mq.delete();
            m_beat  = 0;
            m_phase = M_RUN;
          end
        end
        M_RUN: if (core_ready) begin
          m_beat++;
          if (m_beat == SVM_NUM * CHUNKS) m_phase = M_WAIT;
        end
        M_WAIT: if (core_done) begin
          m_res   = core_result;
          m_phase = M_RESULT;
        end
        M_RESULT: if (res_ready) begin
          m_bias  = (m_bias + 1) % 2048;
          m_phase = M_IDLE;
        end
        default: m_phase = M_LOAD;
      endcase
    end
  end

  // Core/consumer readiness: 0 = always 1 / hold 0, 1 = random / always 1, 2 = pattern 1,0,0,1 / random.
  int cr_mode = 0;
  int rr_mode = 0;
  int cr_idx  = 0;

  initial begin
    core_ready = 1'b1;
    res_ready  = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (cr_mode)
        0: core_ready = 1'b1;
        1: core_ready = 1'($urandom % 2);
        default: begin
          core_ready = (cr_idx % 4 == 0) || (cr_idx % 4 == 3);
          cr_idx++;
        end
      endcase
      case (rr_mode)
        0: res_ready = 1'b0;
        1: res_ready = 1'b1;
        default: res_ready = 1'($urandom % 2);
      endcase
    end
  end

  logic [FW-1:0] stim_feat [FEATURE_NUM];

  task automatic applyStimulus(input int gap, input int count);
    bit acc;
    @(posedge clk); #1;
    for (int i = 0; i < count; i++) begin
      feat_valid = 1'b1;
      feat_data  = stim_feat[i];
      acc = 1'b0;
      for (int t = 0; t < 200 && !acc; t++) begin
        @(negedge clk);
        acc = feat_ready;
        @(posedge clk); #1;
      end
      if (!acc) checkOutput("feat_accept_timeout", 1'b0, 1'b1);
      feat_valid = 1'b0;
      if (i < count - 1) repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic countBeats(output int n);
    bit done;
    n = 0;
    done = 1'b0;
    for (int c = 0; c < 2000 && !done; c++) begin
      @(negedge clk);
      if (!out_valid) done = 1'b1;
      else if (core_ready) n++;
    end
    if (!done) checkOutput("run_timeout", 1'b0, 1'b1);
  endtask

  task automatic pulseDone(input logic [CLASS_WIDE-1:0] r);
    @(posedge clk); #1;
    core_done   = 1'b1;
    core_result = r;
    @(posedge clk); #1;
    core_done   = 1'b0;
  endtask

  task automatic waitFeatReady();
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(negedge clk);
      seen = feat_ready;
    end
    if (!seen) checkOutput("feat_ready_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    bit hit;
    logic [255:0] we;
    rst_n = 1'b0; feat_valid = 1'b0; feat_data = '0; core_done = 1'b0; core_result = '0;
    w_rst_n = 1'b0; w_feat_valid = 1'b0; w_feat_data = '0; w_core_ready = 1'b1;
    w_core_done = 1'b0; w_core_result = '0; w_res_ready = 1'b1;

    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_feat_ready", feat_ready, 1'b1);
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_res_valid", res_valid, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_sv_addr", out_sv_addr, 11'd0);
    checkOutput("rst_chunk", out_chunk, 5'd0);
    checkOutput("rst_first", out_first, 1'b0);
    checkOutput("rst_mode", out_mode, 1'b0);

    // Sample A: features 1..11 back to back, core always ready.
    for (int i = 0; i < FEATURE_NUM; i++) stim_feat[i] = FW'(i + 1);
    applyStimulus(0, FEATURE_NUM);
    @(negedge clk);
    checkOutput("A_latency", out_valid, 1'b1);
    checkOutput("A_b0_lane0", out_data[0 +: FW], 13'd1);
    checkOutput("A_b0_lane7", out_data[7*FW +: FW], 13'd8);
    checkOutput("A_b0_first", out_first, 1'b1);
    checkOutput("A_b0_last", out_last, 1'b0);
    @(negedge clk);
    checkOutput("A_b1_lane0", out_data[0 +: FW], 13'd9);
    checkOutput("A_b1_lane2", out_data[2*FW +: FW], 13'd11);
    checkOutput("A_b1_lane3", out_data[3*FW +: FW], 13'd0);
    checkOutput("A_b1_lane7", out_data[7*FW +: FW], 13'd0);
    checkOutput("A_b1_last", out_last, 1'b1);
    checkOutput("A_b1_sv", out_sv_addr, 11'd0);
    countBeats(n);
    checkOutput("A_beats", 2 + n, 8);
    pulseDone(2'b01);
    @(negedge clk);
    checkOutput("A_res_valid", res_valid, 1'b1);
    checkOutput("A_res_data", res_data, 2'b01);
    repeat (5) begin
      @(negedge clk);
      checkOutput("A_res_hold", {res_valid, res_data}, 3'b101);
    end
    rr_mode = 1;
    waitFeatReady();
    checkOutput("A_bias_next", out_bias_addr, 11'd1);

    // Sample B: all -1, feature every third cycle, core stalls 1,0,0,1.
    for (int i = 0; i < FEATURE_NUM; i++) stim_feat[i] = '1;
    cr_mode = 2;
    rr_mode = 2;
    applyStimulus(2, FEATURE_NUM);
    countBeats(n);
    checkOutput("B_beats", n, 8);
    pulseDone(2'b11);
    waitFeatReady();

    // Random samples, each preceded by a stray core_done while loading.
    for (int s = 0; s < 6; s++) begin
      pulseDone(CLASS_WIDE'($urandom));
      @(negedge clk);
      checkOutput("stray_done_load", res_valid, 1'b0);
      for (int i = 0; i < FEATURE_NUM; i++) stim_feat[i] = FW'($urandom);
      cr_mode = 1;
      applyStimulus(int'($urandom % 3), FEATURE_NUM);
      countBeats(n);
      checkOutput("R_beats", n, 8);
      repeat ($urandom % 4) @(posedge clk);
      pulseDone(CLASS_WIDE'($urandom));
      waitFeatReady();
    end

    // Reset in the middle of RUN at sv_addr 2.
    cr_mode = 0;
    for (int i = 0; i < FEATURE_NUM; i++) stim_feat[i] = FW'($urandom);
    applyStimulus(0, FEATURE_NUM);
    hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(negedge clk);
      hit = out_valid && (out_sv_addr == 11'd2);
    end
    checkOutput("reach_sv2", hit, 1'b1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midrun_feat_ready", feat_ready, 1'b1);
    checkOutput("midrun_out_valid", out_valid, 1'b0);
    checkOutput("midrun_sv", out_sv_addr, 11'd0);
    checkOutput("midrun_chunk", out_chunk, 5'd0);
    checkOutput("midrun_bias", out_bias_addr, 11'd0);
    pulseDone(2'b10);
    @(negedge clk);
    checkOutput("midrun_done_ignored", res_valid, 1'b0);

    // Partial load discarded by reset, then a fresh sample.
    for (int i = 0; i < FEATURE_NUM; i++) stim_feat[i] = FW'($urandom);
    applyStimulus(0, 5);
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < FEATURE_NUM; i++) stim_feat[i] = FW'($urandom);
    cr_mode = 1;
    applyStimulus(1, FEATURE_NUM);
    countBeats(n);
    checkOutput("P_beats", n, 8);
    pulseDone(2'b01);
    waitFeatReady();

    // Wide instance: LANES=16, SVM_NUM=1, FUNCTION=1.
    @(posedge clk); #1 w_rst_n = 1'b1;
    @(negedge clk);
    checkOutput("W_rst_busy", w_busy, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < FEATURE_NUM; i++) begin
      w_feat_valid = 1'b1;
      w_feat_data  = FW'(i + 1);
      @(negedge clk);
      checkOutput("W_feat_ready", w_feat_ready, 1'b1);
      @(posedge clk); #1;
    end
    w_feat_valid = 1'b0;
    we = '0;
    for (int k = 0; k < FEATURE_NUM; k++) we[k*FW +: FW] = FW'(k + 1);
    n = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 0) checkOutput("W_latency", w_out_valid, 1'b1);
      if (w_out_valid) begin
        n++;
        checkOutput("W_data", w_out_data, we);
        checkOutput("W_first_last", {w_out_first, w_out_last}, 2'b11);
        checkOutput("W_sv_chunk", {w_out_sv_addr, w_out_chunk}, 16'd0);
      end
    end
    checkOutput("W_beats", n, 1);
    @(posedge clk); #1;
    w_core_done = 1'b1; w_core_result = 2'b10;
    @(posedge clk); #1 w_core_done = 1'b0;
    @(negedge clk);
    checkOutput("W_res_valid", w_res_valid, 1'b1);
    checkOutput("W_res_data", w_res_data, 2'b10);
    checkOutput("W_mode", w_out_mode, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("W_bias", w_out_bias_addr, 11'd1);
    checkOutput("W_reload_ready", w_feat_ready, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
